mmult_result_printer: RTL and testbench
=======================================

// Module: mmult_result_printer
// PURPOSE
//  Downstream of the 4x4 matrix multiplier. Snapshots the packed 16x18-bit result when the
//  multiplier's level 'valid' rises, then streams it as ASCII hex to a byte sink (UART TX)
//  over a valid/ready handshake. Output is one matrix row per line: 4 entries of 5 uppercase
//  hex digits, separated by ' ', each line ended by CR LF. That is 25 bytes/row, 100 bytes total.
// PARAMETERS
//  ROWS    4   matrix rows (lines printed)
//  COLS    4   entries per row
//  EW      18  entry width in bits; digits per entry ND = ceil(EW/4) = 5 (localparam)
// PORTS
//  clk        in   1                 system clock, all logic on posedge
//  reset_n    in   1                 asynchronous, active-low reset
//  valid      in   1                 multiplier result valid (level, stays high once set)
//  result     in   [0:ROWS*COLS*EW-1] packed result, bit 0 = MSB; C[r][c] at [(r*COLS+c)*EW +: EW]
//  tx_data    out  8                 ASCII byte to sink
//  tx_valid   out  1                 tx_data holds a byte
//  tx_ready   in   1                 sink accepts byte when tx_valid & tx_ready at posedge
//  busy       out  1                 print in progress (capture through last accept)
//  done       out  1                 one-cycle pulse after last byte accepted
// BEHAVIOUR
//  Reset (async, any time): tx_valid=0, tx_data=0, busy=0, done=0, FSM=IDLE, armed=1,
//   all counters 0. A print in progress is abandoned with no partial flush.
//  Trigger rules:
//   - In IDLE with valid=1 and armed=1: at that edge (E0) copy result into the snapshot
//     register, set armed=0, busy=1, and move to LOAD.
//   - armed returns to 1 only when valid is sampled 0.
//   - valid held high after a print does not reprint. A valid rise while busy is ignored.
//  FSM states:
//   IDLE -> LOAD (trigger).
//   LOAD: at E1, present the first digit: tx_valid=1 -> DIGIT.
//   DIGIT: emit the ND digits of entry (r,c), MS nibble first. The top nibble of the 18-bit
//     entry holds bits [17:16], zero-extended.
//     - After the last digit: if c<COLS-1 -> SEP, else -> CR.
//   SEP: emit 0x20, c++, -> DIGIT.
//   CR: emit 0x0D -> LF.
//   LF: emit 0x0A, c=0, r++.
//     - If r was ROWS-1 -> FIN, else -> DIGIT.
//   FIN: tx_valid=0, busy=0, done=1 for exactly one cycle -> IDLE.
//  Handshake:
//   - A state advances only on accept (tx_valid & tx_ready).
//   - While tx_valid=1 & tx_ready=0, tx_data and the state are held stable.
//   - tx_valid never drops before an accept.
//   - tx_valid is registered and never combinationally depends on tx_ready.
//  Throughput: with tx_ready=1, tx_valid is high for exactly 100 consecutive cycles
//   (E1..E100), and done pulses in the cycle after the 100th accept.
//  Hex map: nibble 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
//  Printing always uses the snapshot. Changes on result during a print are ignored.
//  After a reset, if valid is still high, the next edge triggers a complete fresh print.
// TESTING
//  1 result=0, valid rises, tx_ready=1 -> 4x "00000 00000 00000 00000\r\n" (100 B);
//    done pulses once, busy high E0..E100.
//  2 C[0][0]=18'h3FFFF, C[1][2]=18'h12345, C[3][3]=18'h0ABCD, rest 0 ->
//    line0 starts "3FFFF ", line1 field 3 "12345", line3 ends "0ABCD\r\n".
//  3 Case 2 with tx_ready high 1 cycle in 3 -> identical 100-byte stream;
//    tx_data/tx_valid stable on every stalled cycle, no dropped or duplicate bytes.
//  4 valid held high 500 cycles after done -> no further tx_valid.
//    Drop valid 1 cycle, re-raise with new result -> second full print of the new data.
//  5 Change result every cycle during a print -> output matches the value captured at E0;
//    a valid glitch while busy causes no restart.
//  6 Assert reset_n=0 after 40 accepts (async, mid-cycle) -> tx_valid/busy low immediately.
//    Release with valid=1 -> complete 100-byte print starting at "0".

Source files
------------

// File: rtl/mmult_result_printer.sv
// mmult_result_printer: snapshot a packed ROWSxCOLS result and stream it as ASCII hex lines
// Ports:
//   clk       system clock, all logic on posedge
//   reset_n   asynchronous active-low reset
//   valid     multiplier result valid (level)
//   result    packed result, bit 0 = MSB, C[r][c] at [(r*COLS+c)*EW +: EW]
//   tx_data   ASCII byte to the sink
//   tx_valid  tx_data holds a byte
//   tx_ready  sink accepts when tx_valid & tx_ready at posedge
//   busy      print in progress (capture through last accept)
//   done      one-cycle pulse after the last byte is accepted
module mmult_result_printer #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int EW   = 18
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    valid,
    input  logic [0:ROWS*COLS*EW-1] result,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    done
);
    localparam int ND = (EW + 3) / 4;
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int DW = ND > 1 ? $clog2(ND) : 1;
    localparam int SW = $clog2(ROWS * COLS * EW);

    typedef enum logic [2:0] {IDLE, LOAD, DIGIT, SEP, CR, LF, FIN} state_t;

    state_t                  state_q, state_d;
    logic                    armed_q, armed_d;
    logic [0:ROWS*COLS*EW-1] snap_q, snap_d;
    logic [RW-1:0]           r_q, r_d;
    logic [CW-1:0]           c_q, c_d;
    logic [DW-1:0]           d_q, d_d;
    logic                    accept;
    logic [SW-1:0]           base;
    logic [EW-1:0]           entry;
    logic [ND*4-1:0]         ext;
    logic [3:0]              nib;
    logic [7:0]              hex;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            snap_q  <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            snap_q  <= snap_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        snap_d   = snap_q;
        r_d      = r_q;
        c_d      = c_q;
        d_d      = d_q;
        tx_valid = state_q inside {DIGIT, SEP, CR, LF};
        busy     = tx_valid | (state_q == LOAD);
        done     = state_q == FIN;
        accept   = tx_valid & tx_ready;
        base     = SW'((int'(r_q) * COLS + int'(c_q)) * EW);
        entry    = snap_q[base +: EW];
        // top digit holds only the leftover high bits, zero-extended
        ext      = (ND*4)'(entry);
        nib      = 4'(ext >> (4 * (ND - 1 - int'(d_q))));
        hex      = (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};
        tx_data  = (state_q == DIGIT) ? hex :
                   (state_q == SEP)   ? 8'h20 :
                   (state_q == CR)    ? 8'h0D :
                   (state_q == LF)    ? 8'h0A : 8'h00;
        // re-arm only while no print is running, so a valid glitch mid-print is ignored
        if (!valid && (state_q == IDLE || state_q == FIN))
            armed_d = 1'b1;
        case (state_q)
            IDLE: if (valid && armed_q) begin
                snap_d  = result;
                armed_d = 1'b0;
                r_d     = '0;
                c_d     = '0;
                d_d     = '0;
                state_d = LOAD;
            end
            LOAD: state_d = DIGIT;
            DIGIT: if (accept) begin
                d_d     = (d_q == DW'(ND - 1)) ? '0 : d_q + 1'b1;
                state_d = (d_q != DW'(ND - 1)) ? DIGIT : (c_q == CW'(COLS - 1)) ? CR : SEP;
            end
            SEP: if (accept) begin
                c_d     = c_q + 1'b1;
                state_d = DIGIT;
            end
            CR: if (accept) state_d = LF;
            LF: if (accept) begin
                c_d     = '0;
                r_d     = r_q + 1'b1;
                state_d = (r_q == RW'(ROWS - 1)) ? FIN : DIGIT;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mmult_result_printer.sv
// tb_mmult_result_printer: randomized self-checking bench with a byte-level reference model
module tb_mmult_result_printer;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         valid = 1'b0;
    logic [0:287] result = '0;
    logic         tx_ready = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid, busy, done;

    int checks = 0, errors = 0;
    int mode = 0, cyc = 0;
    int ph = 0, sent = 0;
    bit armed = 1'b1;
    logic [7:0] exp_b [100];
    logic [7:0] got [4096];
    logic [7:0] ref2 [100];
    int ngot = 0, vcount = 0, bcount = 0, dcount = 0;
    bit stall_q = 1'b0;
    logic [7:0] stall_d = 8'h00;

    mmult_result_printer dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .result(result),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // mode 0: always ready, 1: ready one cycle in three, 2: random
    always @(posedge clk) begin
        #1;
        cyc++;
        tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    end

    // expected 100-byte text for a given packed result
    task automatic build(input logic [0:287] res);
        int v, nib;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = 0;
                for (int b = 0; b < 18; b++) v = (v << 1) | int'(res[(r*4+c)*18+b]);
                for (int k = 0; k < 5; k++) begin
                    nib = (v >> (4 * (4 - k))) & 15;
                    exp_b[r*25+c*6+k] = (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
                end
                if (c < 3) exp_b[r*25+c*6+5] = 8'h20;
            end
            exp_b[r*25+23] = 8'h0D;
            exp_b[r*25+24] = 8'h0A;
        end
    endtask

    // model phases: 0 idle, 1 captured, 2 sending, 3 finished pulse
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph = 0; armed = 1'b1; sent = 0;
        end else if (ph == 0) begin
            if (valid && armed) begin
                build(result); armed = 1'b0; ph = 1;
            end else if (!valid) armed = 1'b1;
        end else if (ph == 1) begin
            ph = 2; sent = 0;
        end else if (ph == 2) begin
            if (tx_ready) begin
                sent++;
                if (sent == 100) ph = 3;
            end
        end else begin
            ph = 0;
            if (!valid) armed = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk(tx_valid === (ph == 2), "tx_valid", tx_valid, ph == 2);
            chk(busy === (ph == 1 || ph == 2), "busy", busy, ph == 1 || ph == 2);
            chk(done === (ph == 3), "done", done, ph == 3);
            if (ph == 2) chk(tx_data === exp_b[sent], "tx_data", tx_data, exp_b[sent]);
            if (stall_q) chk(tx_valid && tx_data === stall_d, "stall_hold", tx_data, stall_d);
            stall_q = tx_valid && !tx_ready;
            stall_d = tx_data;
            if (tx_valid && tx_ready) begin
                got[ngot] = tx_data;
                ngot++;
            end
            vcount += int'(tx_valid);
            bcount += int'(busy);
            dcount += int'(done);
        end else stall_q = 1'b0;
    end

    task automatic set_entry(input int r, input int c, input logic [17:0] v);
        for (int b = 0; b < 18; b++) result[(r*4+c)*18+b] = v[17-b];
    endtask

    task automatic rand_result();
        for (int i = 0; i < 16; i++) set_entry(i / 4, i % 4, 18'($urandom_range(0, 18'h3FFFF)));
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        chk(ok, name, ok, 1);
        #1;
    endtask

    task automatic chk_str(input int off, input string s, input string name);
        for (int i = 0; i < s.len(); i++) chk(got[off+i] === s[i], name, got[off+i], s[i]);
    endtask

    task automatic rearm(input bit randomize);
        @(posedge clk); #1 valid = 1'b0;
        @(posedge clk); #1 valid = 1'b1;
        if (randomize) rand_result();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1);
    end

    initial begin
        int base, v0, b0, d0;
        bit hit;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(tx_valid === 1'b0, "rst_tx_valid", tx_valid, 0);
        chk(tx_data === 8'h00, "rst_tx_data", tx_data, 0);
        chk(busy === 1'b0, "rst_busy", busy, 0);
        chk(done === 1'b0, "rst_done", done, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // all-zero matrix, sink always ready
        @(posedge clk); #1;
        base = ngot; v0 = vcount; b0 = bcount; d0 = dcount;
        valid = 1'b1;
        wait_done("t1_done");
        chk(ngot - base == 100, "t1_bytes", ngot - base, 100);
        chk(vcount - v0 == 100, "t1_valid_cycles", vcount - v0, 100);
        chk(bcount - b0 == 101, "t1_busy_cycles", bcount - b0, 101);
        chk_str(base, "00000 ", "t1_head");
        chk(got[base+23] === 8'h0D, "t1_cr", got[base+23], 8'h0D);
        chk(got[base+24] === 8'h0A, "t1_lf", got[base+24], 8'h0A);
        chk(got[base+99] === 8'h0A, "t1_last", got[base+99], 8'h0A);
        repeat (5) @(posedge clk);
        #1 chk(dcount - d0 == 1, "t1_done_pulses", dcount - d0, 1);

        // sparse pattern with boundary values
        result = '0;
        set_entry(0, 0, 18'h3FFFF);
        set_entry(1, 2, 18'h12345);
        set_entry(3, 3, 18'h0ABCD);
        rearm(1'b0);
        base = ngot;
        wait_done("t2_done");
        chk(ngot - base == 100, "t2_bytes", ngot - base, 100);
        chk_str(base, "3FFFF ", "t2_line0");
        chk_str(base + 37, "12345", "t2_line1_f3");
        chk_str(base + 93, "0ABCD", "t2_line3_tail");
        chk(got[base+98] === 8'h0D, "t2_cr", got[base+98], 8'h0D);
        chk(got[base+99] === 8'h0A, "t2_lf", got[base+99], 8'h0A);
        for (int i = 0; i < 100; i++) ref2[i] = got[base+i];

        // same data under backpressure
        mode = 1;
        rearm(1'b0);
        base = ngot;
        wait_done("t3_done");
        chk(ngot - base == 100, "t3_bytes", ngot - base, 100);
        for (int i = 0; i < 100; i++) chk(got[base+i] === ref2[i], "t3_same_stream", got[base+i], ref2[i]);

        // valid held high must not reprint; a fresh rise prints new data
        mode = 0;
        v0 = vcount;
        repeat (500) @(posedge clk);
        #1 chk(vcount - v0 == 0, "t4_no_reprint", vcount - v0, 0);
        rearm(1'b1);
        base = ngot;
        wait_done("t4_done");
        chk(ngot - base == 100, "t4_bytes", ngot - base, 100);

        // result churn and a valid glitch during a print
        mode = 2;
        rearm(1'b1);
        base = ngot;
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rand_result();
            if (i == 10) valid = 1'b0;
            if (i == 11) valid = 1'b1;
            if (ngot - base >= 90) begin hit = 1'b1; break; end
        end
        chk(hit, "t5_progress", hit, 1);
        valid = 1'b0;
        wait_done("t5_done");
        chk(ngot - base == 100, "t5_bytes", ngot - base, 100);
        v0 = vcount;
        repeat (20) @(posedge clk);
        #1 chk(vcount - v0 == 0, "t5_no_restart", vcount - v0, 0);

        // asynchronous reset mid-print, then a fresh print with valid still high
        mode = 0;
        @(posedge clk); #1;
        rand_result();
        set_entry(0, 0, 18'h0ABCD);
        valid = 1'b1;
        base = ngot;
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (ngot - base >= 40) begin hit = 1'b1; break; end
        end
        chk(hit, "t6_progress", hit, 1);
        #3 reset_n = 1'b0;
        #1;
        chk(tx_valid === 1'b0, "t6_rst_tx_valid", tx_valid, 0);
        chk(busy === 1'b0, "t6_rst_busy", busy, 0);
        chk(tx_data === 8'h00, "t6_rst_tx_data", tx_data, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        base = ngot;
        wait_done("t6_done");
        chk(ngot - base == 100, "t6_bytes", ngot - base, 100);
        chk_str(base, "0ABCD ", "t6_head");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
